// File: rtl/sort_network_sequencer.sv
// sort_network_sequencer
//   Frames a one-sample-per-cycle stream for an external combinational
//   bitonic sorting network. It collects SIZE samples, tags each with its
//   arrival index and holds them on the network inputs for SETTLE_CYCLES.
//   It then captures the sorted vectors and streams them out in slot order.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready/in_data  input stream (accepted only while filling)
//   net_data_in/net_index_in   load buffer, drives the network inputs
//   net_data_out/net_index_out network outputs, captured after settling
//   out_valid/out_ready        output handshake
//   out_data/out_index         sorted sample and its original arrival index
//   out_last                   final slot of a frame
//   busy                       high while settling or draining
module sort_network_sequencer #(
  parameter int SIZE          = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int NETWORK_WIDTH = 16,
  parameter int INDEX_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NETWORK_WIDTH-1:0]           in_data,
  output logic [SIZE-1:0][NETWORK_WIDTH-1:0] net_data_in,
  output logic [SIZE-1:0][INDEX_WIDTH-1:0]   net_index_in,
  input  logic [SIZE-1:0][NETWORK_WIDTH-1:0] net_data_out,
  input  logic [SIZE-1:0][INDEX_WIDTH-1:0]   net_index_out,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NETWORK_WIDTH-1:0]           out_data,
  output logic [INDEX_WIDTH-1:0]             out_index,
  output logic                               out_last,
  output logic                               busy
);
  localparam int PTR_W = $clog2(SIZE);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT   = PTR_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_SETTLE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t                             r_state, w_state_nxt;
  logic [PTR_W-1:0]                   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]                   r_settle_cnt;
  logic [SIZE-1:0][NETWORK_WIDTH-1:0] r_res_data;
  logic [SIZE-1:0][INDEX_WIDTH-1:0]   r_res_index;

  logic w_accept, w_in_last, w_capture, w_pop;

  // in_ready/out_valid come only from r_state, so these have no
  // combinational path from in_valid/out_ready back to the handshakes.
  assign w_accept  = in_valid && (r_state == S_FILL);
  assign w_in_last = w_accept && (r_wr_ptr == LAST_SLOT);
  assign w_capture = (r_state == S_SETTLE) && (r_settle_cnt == CNT_W'(1));
  assign w_pop     = out_valid && out_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:   if (w_in_last) w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_capture) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_pop && (r_rd_ptr == LAST_SLOT)) w_state_nxt = S_FILL;
      default:  w_state_nxt = S_FILL;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_index = '0;
    case (r_state)
      S_FILL:   in_ready = 1'b1;
      S_SETTLE: busy     = 1'b1;
      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = r_res_data[r_rd_ptr];
        out_index = r_res_index[r_rd_ptr];
        out_last  = (r_rd_ptr == LAST_SLOT);
      end
      default: ;
    endcase
  end

  // ---------------- pointers, settle counter, result buffer ----------------
  // SIZE is a power of two, so both pointers wrap to 0 after the last slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_settle_cnt <= '0;
      r_res_data   <= '0;
      r_res_index  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_in_last)
        r_settle_cnt <= SETTLE_INIT;
      else if ((r_state == S_SETTLE) && (r_settle_cnt != '0))
        r_settle_cnt <= r_settle_cnt - CNT_W'(1);
      if (w_capture) begin
        r_res_data  <= net_data_out;
        r_res_index <= net_index_out;
        r_rd_ptr    <= '0;
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // ---------------- load buffer, one register pair per network slot -------
  for (genvar s = 0; s < SIZE; s++) begin : g_slot
    logic [NETWORK_WIDTH-1:0] r_ld_data;
    logic [INDEX_WIDTH-1:0]   r_ld_index;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ld_data  <= '0;
        r_ld_index <= '0;
      end else if (w_accept && (r_wr_ptr == PTR_W'(s))) begin
        r_ld_data  <= in_data;
        r_ld_index <= INDEX_WIDTH'(r_wr_ptr);
      end
    end

    assign net_data_in[s]  = r_ld_data;
    assign net_index_in[s] = r_ld_index;
  end

endmodule

// File: doc/sort_network_sequencer.md
# sort_network_sequencer

Sequential controller that feeds the combinational bitonic sorting network (`comparison_size_x`, instantiated alongside this block) from a one-sample-per-cycle stream. It collects a frame of SIZE samples, tags each with its arrival index, and holds them on the network inputs for a fixed settle time. It then registers the sorted data/index vectors and streams them out in network slot order with valid/ready handshaking. It sits between the BPSK metric producer and any downstream peak/rank logic.

## Interface

Parameters (NETWORK_WIDTH and INDEX_WIDTH come from the shared `parameters.svh`):
- `SIZE`, default 8: frame length. Power of two, ≥2. Must equal the SIZE of the attached network. Requires INDEX_WIDTH ≥ $clog2(SIZE).
- `SETTLE_CYCLES`, default 1: cycles the network inputs are held stable before capture. Must be ≥1.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: input sample valid.
- `in_ready`, out, 1: block accepts a sample this cycle.
- `in_data`, in, NETWORK_WIDTH: input sample.
- `net_data_in`, out, [SIZE][NETWORK_WIDTH]: drives the network data_in.
- `net_index_in`, out, [SIZE][INDEX_WIDTH]: drives the network index_in.
- `net_data_out`, in, [SIZE][NETWORK_WIDTH]: network data_out.
- `net_index_out`, in, [SIZE][INDEX_WIDTH]: network index_out.
- `out_valid`, out, 1: sorted element valid.
- `out_ready`, in, 1: downstream accepts the element.
- `out_data`, out, NETWORK_WIDTH: sorted sample.
- `out_index`, out, INDEX_WIDTH: original arrival index of `out_data`.
- `out_last`, out, 1: high with the final element (slot SIZE-1) of a frame.
- `busy`, out, 1: high in SETTLE and DRAIN.

## Operation

- Storage:
  - Load buffer `ld_data[SIZE]`, `ld_index[SIZE]`, wired directly to `net_*_in`.
  - Result buffer `res_data[SIZE]`, `res_index[SIZE]`.
  - `wr_ptr` and `rd_ptr`, $clog2(SIZE) bits each.
  - `settle_cnt`, $clog2(SETTLE_CYCLES+1) bits.
- FILL:
  - `in_ready`=1.
  - On `in_valid && in_ready`: `ld_data[wr_ptr]`←`in_data`, `ld_index[wr_ptr]`←`wr_ptr` (zero-extended), `wr_ptr`++.
  - On the accept with `wr_ptr`==SIZE-1: `wr_ptr`←0, `settle_cnt`←SETTLE_CYCLES, go to SETTLE.
  - `in_valid`=0 cycles are bubbles. Nothing changes during a bubble.
- SETTLE:
  - `in_ready`=0. The load buffer is frozen.
  - `settle_cnt` decrements each cycle.
  - In the cycle where `settle_cnt`==1: `res_*`←`net_*_out`, `rd_ptr`←0, go to DRAIN.
- DRAIN:
  - `out_valid`=1. `out_data`=`res_data[rd_ptr]`, `out_index`=`res_index[rd_ptr]`.
  - `out_last`=(`rd_ptr`==SIZE-1).
  - On `out_valid && out_ready`: `rd_ptr`++. If `out_last`, go to FILL.
  - While `out_ready`=0, outputs hold stable.
- `in_ready`=0 outside FILL. `out_valid`=0 outside DRAIN. No overlap of fill and drain.
- Output order is network slot 0..SIZE-1. With the UP=1 network this is ascending: smallest first.
- Equal values: order is whatever the network produces. The block never reorders.
- Unused state encodings recover to FILL.

## Timing

- Reset (async assert, sync release) values:
  - State FILL; `wr_ptr`, `rd_ptr`, `settle_cnt` = 0.
  - All `ld_*` and `res_*` = 0.
  - `out_valid`, `out_last`, `busy` = 0; `out_data`, `out_index` = 0.
  - `in_ready`=1 once state is FILL.
- Latency:
  - The last input is accepted at edge T.
  - SETTLE occupies cycles T+1 … T+SETTLE_CYCLES.
  - Capture happens at the end of cycle T+SETTLE_CYCLES.
  - `out_valid` rises in cycle T+SETTLE_CYCLES+1.
- Throughput, with no stalls: one frame per 2·SIZE+SETTLE_CYCLES cycles.
- `in_ready` and `out_valid` are pure decodes of registered state. There are no combinational paths from `in_valid`/`out_ready` to them.
- `in_valid` asserted during SETTLE/DRAIN is ignored and not consumed.
- Reset mid-frame (any state) discards all buffered data. The first beat after release is index 0 of a new frame.

## Test plan

- Basic sort, SIZE=8, SETTLE_CYCLES=1, UP=1, `out_ready`=1:
  - Stimulus: inputs 5,3,7,0,6,2,4,1.
  - Required: out (data,index) = (0,3),(1,7),(2,5),(3,1),(4,6),(5,0),(6,4),(7,2); `out_last` only on the 8th beat; first `out_valid` 2 cycles after the 8th accept.
- Backpressure: same frame, `out_ready` low for 3 cycles at `rd_ptr`=2 → element (2,5) held stable across all 3 cycles; no loss or duplication; frame completes in order.
- Input bubbles: `in_valid` toggled 1,0,1,0… → `wr_ptr` advances only on accepts; indices still 0..7 by accept order; result identical to the basic-sort case.
- Settle length: SETTLE_CYCLES=3 → `busy`=1 and `in_ready`=0 for 3 cycles; `out_valid` rises 4 cycles after the last accept; `in_valid` asserted meanwhile is not consumed.
- Reset mid-DRAIN: assert `rst_n`=0 after 4 outputs → `out_valid`=0 immediately (async); after release, a new frame of 8 samples of 9 → out data all 9, indices a permutation of 0..7.
- Back-to-back frames, two consecutive 8-sample frames with all-max (2^NETWORK_WIDTH−1) values → second frame accepted only after the first `out_last` handshake; both frames drain correctly.
